// File: rtl/cycle_counter_ctrl.sv
// Parametrised cycling counter (up/down/bounce/hold) with load, wrap pulse and display mapping.
// Optional internal tick prescaler enabled by defining CYCLE_PRESCALE_EN.
module cycle_counter_ctrl #(
  parameter int WIDTH        = 4,
  parameter int REVERSE      = 1,
  parameter int ACTIVE_LOW   = 1,
  parameter int PRESCALE_DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] disp,
  output logic             wrap,
  output logic             dir_down
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] count_inc, count_dec;
  logic             dir_reg, dir_next;
  logic             wrap_reg, wrap_next;
  logic             tick;
  logic             advance;

`ifdef CYCLE_PRESCALE_EN
  localparam int PS_W = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0] ps_reg;
  logic            unused_tick_in;

  assign unused_tick_in = tick_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_reg <= '0;
    end else if (ps_reg == PS_LAST) begin
      ps_reg <= '0;
    end else begin
      ps_reg <= ps_reg + PS_W'(1);
    end
  end

  assign tick = (ps_reg == PS_LAST);
`else
  logic unused_prescale_div;

  assign unused_prescale_div = (PRESCALE_DIV >= 2);
  assign tick = tick_in;
`endif

  assign advance   = tick && en && !load && (mode != MODE_HOLD);
  assign count_inc = count_reg + ONE;
  assign count_dec = count_reg - ONE;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      dir_reg   <= 1'b0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Next-state logic; count_inc is only used once count_reg < limit, so it cannot overflow
  always_comb begin
    count_next = count_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_val > limit) ? limit : load_val;
      dir_next   = 1'b0;
    end else if (advance) begin
      if (limit == '0) begin
        count_next = '0;
        dir_next   = 1'b0;
        wrap_next  = 1'b1;
      end else begin
        case (mode)
          MODE_UP: begin
            dir_next = 1'b0;
            if (count_reg < limit) begin
              count_next = count_inc;
            end else begin
              count_next = '0;
              wrap_next  = 1'b1;
            end
          end
          MODE_DOWN: begin
            dir_next = 1'b0;
            if (count_reg == '0) begin
              count_next = limit;
              wrap_next  = 1'b1;
            end else if (count_reg > limit) begin
              count_next = limit;
            end else begin
              count_next = count_dec;
            end
          end
          MODE_BOUNCE: begin
            if (count_reg > limit) begin
              count_next = limit;
              dir_next   = 1'b1;
              wrap_next  = 1'b1;
            end else if (!dir_reg) begin
              if ((count_reg < limit) && (count_inc < limit)) begin
                count_next = count_inc;
              end else begin
                count_next = limit;
                dir_next   = 1'b1;
                wrap_next  = 1'b1;
              end
            end else begin
              if (count_reg > ONE) begin
                count_next = count_dec;
              end else begin
                count_next = '0;
                dir_next   = 1'b0;
                wrap_next  = 1'b1;
              end
            end
          end
          default: begin
            count_next = count_reg;
          end
        endcase
      end
    end
  end

  // Output mapping
  logic [WIDTH-1:0] ordered;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (REVERSE != 0) begin : g_rev
        assign ordered[gi] = count_reg[WIDTH-1-gi];
      end else begin : g_fwd
        assign ordered[gi] = count_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    count    = count_reg;
    wrap     = wrap_reg;
    dir_down = dir_reg;
    disp     = (ACTIVE_LOW != 0) ? ~ordered : ordered;
  end

endmodule

// File: tb/tb_cycle_counter_ctrl.sv
// Directed self-checking bench for cycle_counter_ctrl (default parameters).
// With CYCLE_PRESCALE_EN defined it instead checks the internal prescaler at PRESCALE_DIV=4.
module tb_cycle_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       en;
  logic [1:0] mode;
  logic [3:0] limit;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [3:0] disp;
  logic       wrap;
  logic       dir_down;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  cycle_counter_ctrl #(
    .WIDTH        (4),
    .REVERSE      (1),
    .ACTIVE_LOW   (1),
    .PRESCALE_DIV (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .en       (en),
    .mode     (mode),
    .limit    (limit),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .disp     (disp),
    .wrap     (wrap),
    .dir_down (dir_down)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst_n %0b tick %0b en %0b mode %0d limit %0d load %0b -> count %0d disp %h wrap %0b dir %0b",
             cyc, rst_n, tick_in, en, mode, limit, load, count, disp, wrap, dir_down);
  endtask

  task automatic expect_cw(input string tag, input int c, input int w);
    check({tag, "_count"}, 32'(count), 32'(c));
    check({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask

  int bc[9] = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
  int bw[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int bd[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    rst_n = 1'b0; tick_in = 1'b1; en = 1'b1; mode = 2'b00; limit = 4'd15;
    load = 1'b0; load_val = 4'd0;
    step(); step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_disp", 32'(disp), 32'hF);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_dir", 32'(dir_down), 32'd0);

`ifdef CYCLE_PRESCALE_EN
    tick_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_cw("ps_wait1", 0, 0);
    end
    step();
    expect_cw("ps_tick1", 1, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_cw("ps_wait2", 1, 0);
    end
    step();
    expect_cw("ps_tick2", 2, 0);
`else
    // Up count through full range
    rst_n = 1'b1;
    step();
    expect_cw("up1", 1, 0);
    check("up1_disp", 32'(disp), 32'h7);
    for (int i = 2; i <= 15; i++) begin
      step();
      expect_cw("up", i, 0);
    end
    step();
    expect_cw("up_wrap", 0, 1);
    step();
    expect_cw("up_after", 1, 0);

    // Down count, limit 9
    mode = 2'b01; limit = 4'd9; load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    expect_cw("dn_load", 0, 0);
    step();
    expect_cw("dn_wrap1", 9, 1);
    for (int i = 8; i >= 0; i--) begin
      step();
      expect_cw("dn", i, 0);
    end
    step();
    expect_cw("dn_wrap2", 9, 1);

    // Bounce, limit 3, from reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; mode = 2'b10; limit = 4'd3;
    for (int i = 0; i < 9; i++) begin
      step();
      expect_cw("bnc", bc[i], bw[i]);
      check("bnc_dir", 32'(dir_down), 32'(bd[i]));
    end
    mode = 2'b00;
    step();
    expect_cw("bnc_leave", 0, 1);
    check("bnc_leave_dir", 32'(dir_down), 32'd0);

    // Load clamps and wins over a coincident tick
    limit = 4'd9; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    expect_cw("ld_clamp", 9, 0);
    step();
    expect_cw("ld_next", 0, 1);

    // Limit lowered below count, then freeze
    limit = 4'd15; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    expect_cw("lim_load", 12, 0);
    check("lim_disp", 32'(disp), 32'hC);
    limit = 4'd5;
    step();
    expect_cw("lim_up", 0, 1);
    step();
    expect_cw("lim_up1", 1, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_cw("frz", 1, 0);
    end
    en = 1'b1; limit = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_cw("lim0", 0, 1);
    end
    mode = 2'b10;
    step();
    expect_cw("lim0_bnc", 0, 1);
    check("lim0_bnc_dir", 32'(dir_down), 32'd0);

    // Down with count above limit, then hold
    mode = 2'b01; limit = 4'd15; load = 1'b1; load_val = 4'd12;
    step();
    load = 1'b0;
    limit = 4'd5;
    step();
    expect_cw("dn_clamp", 5, 0);
    mode = 2'b11;
    step();
    expect_cw("hold", 5, 0);

    // Reset mid-run with tick high
    mode = 2'b00; limit = 4'd15; load = 1'b1; load_val = 4'd6;
    step();
    load = 1'b0;
    step();
    expect_cw("pre_rst", 7, 0);
    check("pre_rst_disp", 32'(disp), 32'h1);
    rst_n = 1'b0;
    step();
    expect_cw("mid_rst", 0, 0);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_counter_ctrl.md
Name: cycle_counter_ctrl

Overview:
- Parametrised successor to the single-purpose 4-bit digit cycler.
- Cycling counter with:
  - configurable width and programmable limit;
  - up, down, bounce and hold modes;
  - synchronous load;
  - one-cycle wrap pulse;
  - display mapping with optional bit-reverse and active-low inversion, for anode/LED drive.
- Runs on the fast system clock and advances on a tick enable, so no derived slow clock is needed.
- Sits between the tick/prescaler logic and the display or LED drivers.

Parameters:
- WIDTH, 4, counter/limit/load/display width in bits (2..16).
- REVERSE, 1, 1 = disp is count bit-reversed (bit 0 drives disp MSB).
- ACTIVE_LOW, 1, 1 = disp is inverted after any reversal.
- PRESCALE_DIV, 100000000, internal tick divide ratio; used only with CYCLE_PRESCALE_EN; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- tick_in  in  1  advance strobe, one clk wide.
- en  in  1  1 = count on tick; 0 = freeze.
- mode  in  2  00 up, 01 down, 10 bounce, 11 hold.
- limit  in  WIDTH  terminal value; count range is 0..limit.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  raw registered count.
- disp  out  WIDTH  mapped display value, combinational from count.
- wrap  out  1  registered one-cycle pulse at endpoint.
- dir_down  out  1  current bounce direction; 1 = descending.

Behaviour:
- Reset (rst_n=0 at posedge) overrides everything:
  - count=0, wrap=0, dir_down=0.
  - disp = map(0), which is all ones with default parameters.
  - Reset with tick_in high still yields count=0.
- Priority per edge: reset > load > advance > hold.
- Load (load=1):
  - count = min(load_val, limit); dir_down=0; wrap=0.
  - Takes priority over a coincident tick; that tick is lost.
- Advance: occurs when tick_in && en && !load, and mode != 11.
  - count updates at the same edge; latency from tick to new count is one clk.
- Mode 00 (up):
  - count < limit: count+1, wrap=0.
  - count >= limit: count=0, wrap=1.
- Mode 01 (down):
  - count = 0: count=limit, wrap=1.
  - count > limit: count=limit, wrap=0.
  - otherwise: count-1, wrap=0.
- Mode 10 (bounce):
  - Ascending, count+1 < limit: count+1.
  - Ascending, reaching limit: count=limit, dir_down=1, wrap=1.
  - Descending, count-1 > 0: count-1.
  - Descending, reaching 0: count=0, dir_down=0, wrap=1.
  - count > limit on an advance: count=limit, dir_down=1, wrap=1.
- limit = 0:
  - count held at 0; every advance sets wrap=1.
  - dir_down stays 0.
- Hold (mode 11) or no advance:
  - count and dir_down unchanged; wrap=0.
- wrap is high for exactly one clk after the advancing edge, including under back-to-back ticks.
- Mode change mid-run:
  - Takes effect at the next advance; no reset of count.
  - Leaving bounce clears dir_down at the next advance.
- Arithmetic: all arithmetic is WIDTH bits.
  - No overflow is possible, since count+1 is computed only when count < limit <= 2^WIDTH-1.
- disp mapping: bit-reverse if REVERSE=1, then invert if ACTIVE_LOW=1.

Optional Feature:
- Macro: CYCLE_PRESCALE_EN.
- Defined:
  - An internal counter of ceil(log2(PRESCALE_DIV)) bits counts 0..PRESCALE_DIV-1 and is cleared by rst_n.
  - It generates a one-clk tick when it wraps; tick_in is ignored.
  - First internal tick occurs PRESCALE_DIV clks after reset release.
- Undefined: tick_in is the sole advance strobe; no prescaler logic is synthesised.

Test Plan:
- Reset/up: WIDTH=4, REVERSE=1, ACTIVE_LOW=1, mode=00, limit=15, en=1, tick every clk.
  - After reset: count=0, disp=4'hF.
  - Count=1 gives disp=4'h7.
  - Count steps 1..15 then 0; wrap=1 only for the cycle after the 15->0 edge.
- Down: mode=01, limit=9, start count=0, tick.
  - Sequence 9(wrap=1), 8, 7 … 0, then 9(wrap=1).
- Bounce: mode=10, limit=3, from reset.
  - Sequence 1, 2, 3(wrap, dir_down=1), 2, 1, 0(wrap, dir_down=0), 1.
- Load/clamp: limit=9, load=1, load_val=12, tick_in=1 same edge.
  - count=9, wrap=0, no advance.
  - Next tick (up): count=0, wrap=1.
- Limit change and freeze:
  - count=12, limit set to 5, up tick: count=0, wrap=1.
  - en=0 with 5 ticks: count unchanged.
  - limit=0: each tick keeps count=0, wrap=1.
- Reset mid-run/prescaler:
  - rst_n=0 with tick_in=1 at count=7: next count=0, wrap=0.
  - With CYCLE_PRESCALE_EN, PRESCALE_DIV=4, tick_in=0: count advances every 4 clks.
